// File: rtl/ifm_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// ifm_skew_feeder_pkg
// Shared types and helpers for the input-feature-map skew feeder.
//   DEF_HEIGHT / DEF_IWIDTH / DEF_CNT_W : default array geometry
//   elem_t    : one signed feature-map element at the default width
//   fsm_t     : tile framing states
//   flush_len : number of FLUSH cycles for a given array height
// ---------------------------------------------------------------------------
package ifm_skew_feeder_pkg;

  localparam int DEF_HEIGHT = 32;
  localparam int DEF_IWIDTH = 16;
  localparam int DEF_CNT_W  = 16;

  typedef logic signed [DEF_IWIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fsm_t;

  // The clr token needs one cycle to enter the skew plus HEIGHT cycles to
  // reach the last row.
  function automatic int flush_len(input int height);
    return height + 1;
  endfunction

endpackage

// File: rtl/ifm_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// ifm_skew_feeder_if
// Upstream valid/ready vector stream into the skew feeder.
//   s_valid : vector valid            (master -> slave)
//   s_last  : final vector of a tile  (master -> slave)
//   s_data  : HEIGHT signed lanes     (master -> slave)
//   s_ready : feeder can accept       (slave  -> master)
// ---------------------------------------------------------------------------
interface ifm_skew_feeder_if
  import ifm_skew_feeder_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int IWIDTH = DEF_IWIDTH
) ();

  logic                     s_valid;
  logic                     s_ready;
  logic                     s_last;
  logic signed [IWIDTH-1:0] s_data [HEIGHT-1:0];

  modport master (output s_valid, output s_last, output s_data, input s_ready);
  modport slave  (input s_valid, input s_last, input s_data, output s_ready);

endinterface

// File: rtl/ifm_skew_feeder_lane.sv
// ---------------------------------------------------------------------------
// skew_lane
// DEPTH-register delay line carrying {en, clr, data} for one array row.
//   clk, rst_n         : clock, asynchronous active-low reset
//   en_in/clr_in/data_in    : token entering the lane
//   en_out/clr_out/data_out : token DEPTH cycles later
// Build option IFM_SKEW_ZERO_GATE_EN: data stages load 0 for bubbles instead
// of holding the last valid element.
// ---------------------------------------------------------------------------
module skew_lane #(
  parameter int DEPTH  = 1,
  parameter int IWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_in,
  input  logic                     clr_in,
  input  logic signed [IWIDTH-1:0] data_in,
  output logic                     en_out,
  output logic                     clr_out,
  output logic signed [IWIDTH-1:0] data_out
);

  logic                     en_q   [DEPTH];
  logic                     clr_q  [DEPTH];
  logic signed [IWIDTH-1:0] data_q [DEPTH];

  // NOTE: the data stages are reset along with en/clr so ifm reads 0 out of
  // reset and a reset mid-tile leaves no stale elements in the rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        en_q[k]   <= 1'b0;
        clr_q[k]  <= 1'b0;
        data_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, so the loop order cannot collapse the chain.
      en_q[0]  <= en_in;
      clr_q[0] <= clr_in;
`ifdef IFM_SKEW_ZERO_GATE_EN
      data_q[0] <= en_in ? data_in : '0;
`else
      if (en_in) data_q[0] <= data_in;
`endif
      for (int k = 1; k < DEPTH; k++) begin
        en_q[k]  <= en_q[k-1];
        clr_q[k] <= clr_q[k-1];
`ifdef IFM_SKEW_ZERO_GATE_EN
        data_q[k] <= en_q[k-1] ? data_q[k-1] : '0;
`else
        if (en_q[k-1]) data_q[k] <= data_q[k-1];
`endif
      end
    end
  end

  assign en_out   = en_q[DEPTH-1];
  assign clr_out  = clr_q[DEPTH-1];
  assign data_out = data_q[DEPTH-1];

endmodule

// File: rtl/ifm_skew_feeder.sv
// ---------------------------------------------------------------------------
// ifm_skew_feeder
// Frames input-feature-map vectors into tiles and feeds them to the systolic
// array rows with diagonal skew (row h delayed h cycles after row 0).
//   clk, rst_n  : clock, asynchronous active-low reset
//   up          : upstream vector stream (slave modport)
//   ifm         : skewed row data
//   en_i, clr_i : skewed per-row data-valid and clear
//   busy        : tile in progress (STREAM or FLUSH)
//   tile_done   : one-cycle pulse coincident with clr_i[HEIGHT-1]
//   tile_beats  : beat count of the last completed tile (saturating)
// Build option IFM_SKEW_ZERO_GATE_EN: ifm rows read 0 while en_i is low.
// ---------------------------------------------------------------------------
module ifm_skew_feeder
  import ifm_skew_feeder_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ifm_skew_feeder_if.slave         up,
  output logic signed [IWIDTH-1:0] ifm [HEIGHT-1:0],
  output logic [HEIGHT-1:0]        en_i,
  output logic [HEIGHT-1:0]        clr_i,
  output logic                     busy,
  output logic                     tile_done,
  output logic [CNT_W-1:0]         tile_beats
);

  localparam int FLUSH_LEN = flush_len(HEIGHT);
  localparam int FL_W      = $clog2(FLUSH_LEN);

  fsm_t             state, state_n;
  logic [FL_W-1:0]  fl_cnt, fl_cnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] tile_beats_n;
  logic             accept;
  logic             clr_tok;

  assign up.s_ready = (state != FLUSH);
  assign accept     = up.s_valid && up.s_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fl_cnt     <= '0;
      cnt        <= '0;
      tile_beats <= '0;
    end else begin
      state      <= state_n;
      fl_cnt     <= fl_cnt_n;
      cnt        <= cnt_n;
      tile_beats <= tile_beats_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path through
    // the case leaves a variable unassigned and no latch is inferred.
    state_n      = state;
    fl_cnt_n     = fl_cnt;
    cnt_n        = cnt;
    tile_beats_n = tile_beats;
    tile_done    = 1'b0;
    clr_tok      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n    = CNT_W'(1);
          fl_cnt_n = '0;
          state_n  = up.s_last ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
          if (up.s_last) begin
            fl_cnt_n = '0;
            state_n  = FLUSH;
          end
        end
      end
      FLUSH: begin
        // The clr token enters the skew on the first FLUSH cycle, directly
        // behind the tile's last en beat.
        clr_tok = (fl_cnt == '0);
        if (fl_cnt == FL_W'(FLUSH_LEN - 1)) begin
          tile_done    = 1'b1;
          tile_beats_n = cnt;
          cnt_n        = '0;
          fl_cnt_n     = '0;
          state_n      = IDLE;
        end else begin
          fl_cnt_n = fl_cnt + FL_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    skew_lane #(
      .DEPTH  (h + 1),
      .IWIDTH (IWIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_in    (accept),
      .clr_in   (clr_tok),
      .data_in  (up.s_data[h]),
      .en_out   (en_i[h]),
      .clr_out  (clr_i[h]),
      .data_out (ifm[h])
    );
  end

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_ifm_skew_feeder
// Directed bench for ifm_skew_feeder at HEIGHT=4, IWIDTH=16, CNT_W=3.
// Per-edge vectors hold the inputs presented before an edge and the outputs
// expected just after it; ifm is compared on rows whose en_i is expected high.
// ---------------------------------------------------------------------------
module tb_ifm_skew_feeder;

  localparam int H  = 4;
  localparam int W  = 16;
  localparam int CW = 3;

`ifdef IFM_SKEW_ZERO_GATE_EN
  localparam logic [W-1:0] BUBBLE_20 = 16'd0;
`else
  localparam logic [W-1:0] BUBBLE_20 = 16'd20;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] ifm [H-1:0];
  logic [H-1:0]        en_i;
  logic [H-1:0]        clr_i;
  logic                busy;
  logic                tile_done;
  logic [CW-1:0]       tile_beats;

  ifm_skew_feeder_if #(.HEIGHT(H), .IWIDTH(W)) bus ();

  ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (bus),
    .ifm        (ifm),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .busy       (busy),
    .tile_done  (tile_done),
    .tile_beats (tile_beats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          v;
    logic          l;
    logic [H-1:0][W-1:0] d;
    logic          rdy;
    logic          bsy;
    logic [H-1:0]  en;
    logic [H-1:0]  clr;
    logic          done;
    logic [CW-1:0] beats;
    logic [H-1:0][W-1:0] ifm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [H*W-1:0] rep(input logic [W-1:0] x);
    return {H{x}};
  endfunction

  function automatic logic [H*W-1:0] row4(input int r3, input int r2, input int r1, input int r0);
    return {W'(r3), W'(r2), W'(r1), W'(r0)};
  endfunction

  function automatic vec_t mk(input logic v, input logic l, input logic [H*W-1:0] d,
                              input logic rdy, input logic bsy, input logic [H-1:0] en,
                              input logic [H-1:0] clr, input logic done,
                              input logic [CW-1:0] beats, input logic [H*W-1:0] ifm_e);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.rdy = rdy; r.bsy = bsy; r.en = en;
    r.clr = clr; r.done = done; r.beats = beats; r.ifm = ifm_e;
    return r;
  endfunction

  task automatic drive(input logic v, input logic l, input logic [H-1:0][W-1:0] d);
    bus.s_valid = v;
    bus.s_last  = l;
    for (int h = 0; h < H; h++) bus.s_data[h] = d[h];
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t e);
    check($sformatf("v%0d_ready", i), 64'(bus.s_ready), 64'(e.rdy));
    check($sformatf("v%0d_busy", i), 64'(busy), 64'(e.bsy));
    check($sformatf("v%0d_en_i", i), 64'(en_i), 64'(e.en));
    check($sformatf("v%0d_clr_i", i), 64'(clr_i), 64'(e.clr));
    check($sformatf("v%0d_tile_done", i), 64'(tile_done), 64'(e.done));
    check($sformatf("v%0d_tile_beats", i), 64'(tile_beats), 64'(e.beats));
    for (int h = 0; h < H; h++)
      if (e.en[h]) check($sformatf("v%0d_ifm%0d", i, h), 64'($unsigned(ifm[h])), 64'(e.ifm[h]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_done, saw_en, ifm_any;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    #12;
    check("rst_en_i", 64'(en_i), 64'd0);
    check("rst_clr_i", 64'(clr_i), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_tile_beats", 64'(tile_beats), 64'd0);
    check("rst_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat tile {4,3,2,1}.
    vecs.push_back(mk(1,1,row4(4,3,2,1), 0,1,4'b0001,4'b0000,0,0, row4(0,0,0,1)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0010,4'b0001,0,0, row4(0,0,2,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0100,4'b0010,0,0, row4(0,3,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1000,4'b0100,0,0, row4(4,0,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0000,4'b1000,1,0, '0));
    vecs.push_back(mk(0,0,'0,            1,0,4'b0000,4'b0000,0,1, '0));
    // Three back-to-back beats 10,20,30; next accept right after tile_done.
    vecs.push_back(mk(1,0,rep(10),       1,1,4'b0001,4'b0000,0,1, row4(0,0,0,10)));
    vecs.push_back(mk(1,0,rep(20),       1,1,4'b0011,4'b0000,0,1, row4(0,0,10,20)));
    vecs.push_back(mk(1,1,rep(30),       0,1,4'b0111,4'b0000,0,1, row4(0,10,20,30)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1110,4'b0001,0,1, row4(10,20,30,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1100,4'b0010,0,1, row4(20,30,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1000,4'b0100,0,1, row4(30,0,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0000,4'b1000,1,1, '0));
    vecs.push_back(mk(0,0,'0,            1,0,4'b0000,4'b0000,0,3, '0));
    // Beat 5, gap carrying a stray s_last, beat 7 with last.
    vecs.push_back(mk(1,0,rep(5),        1,1,4'b0001,4'b0000,0,3, row4(0,0,0,5)));
    vecs.push_back(mk(0,1,'0,            1,1,4'b0010,4'b0000,0,3, row4(0,0,5,0)));
    vecs.push_back(mk(1,1,rep(7),        0,1,4'b0101,4'b0000,0,3, row4(0,5,0,7)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1010,4'b0001,0,3, row4(5,0,7,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0100,4'b0010,0,3, row4(0,7,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1000,4'b0100,0,3, row4(7,0,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0000,4'b1000,1,3, '0));
    vecs.push_back(mk(0,0,'0,            1,0,4'b0000,4'b0000,0,2, '0));
    // Valid held high through FLUSH: vector 50 waits, then is taken once.
    vecs.push_back(mk(1,1,rep(40),       0,1,4'b0001,4'b0000,0,2, row4(0,0,0,40)));
    vecs.push_back(mk(1,0,rep(50),       0,1,4'b0010,4'b0001,0,2, row4(0,0,40,0)));
    vecs.push_back(mk(1,0,rep(50),       0,1,4'b0100,4'b0010,0,2, row4(0,40,0,0)));
    vecs.push_back(mk(1,0,rep(50),       0,1,4'b1000,4'b0100,0,2, row4(40,0,0,0)));
    vecs.push_back(mk(1,1,rep(50),       0,1,4'b0000,4'b1000,1,2, '0));
    vecs.push_back(mk(1,1,rep(50),       1,0,4'b0000,4'b0000,0,1, '0));
    vecs.push_back(mk(1,1,rep(50),       0,1,4'b0001,4'b0000,0,1, row4(0,0,0,50)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0010,4'b0001,0,1, row4(0,0,50,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0100,4'b0010,0,1, row4(0,50,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b1000,4'b0100,0,1, row4(50,0,0,0)));
    vecs.push_back(mk(0,0,'0,            0,1,4'b0000,4'b1000,1,1, '0));
    vecs.push_back(mk(0,0,'0,            1,0,4'b0000,4'b0000,0,1, '0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].l, vecs[i].d);
      edge1();
      check_vec(i, vecs[i]);
    end

    // Counter saturation: nine beats into a 3-bit counter.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, (i == 8), rep(W'(i + 1)));
      edge1();
    end
    drive(1'b0, 1'b0, '0);
    n = 0;
    while (n < 20 && !tile_done) begin
      edge1();
      n++;
    end
    check("sat_done_latency", 64'(n), 64'd4);
    check("sat_clr3_with_done", 64'(clr_i[H-1]), 64'd1);
    edge1();
    check("sat_tile_beats", 64'(tile_beats), 64'd7);
    check("sat_ready_after", 64'(bus.s_ready), 64'd1);

    // Reset while beats 2 and 3 are still in the skew.
    drive(1'b1, 1'b0, rep(60)); edge1();
    drive(1'b1, 1'b0, rep(70)); edge1();
    drive(1'b1, 1'b0, rep(80)); edge1();
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_en_i", 64'(en_i), 64'b0111);
    #3;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    #1;
    ifm_any = 1'b0;
    for (int h = 0; h < H; h++) ifm_any |= (ifm[h] != '0);
    check("mid_rst_en_i", 64'(en_i), 64'd0);
    check("mid_rst_clr_i", 64'(clr_i), 64'd0);
    check("mid_rst_ifm_any", 64'(ifm_any), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_tile_beats", 64'(tile_beats), 64'd0);
    check("mid_rst_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    saw_en   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge1();
      saw_done |= tile_done;
      saw_en   |= (en_i != '0) | (clr_i != '0) | busy;
    end
    check("post_rst_no_done", 64'(saw_done), 64'd0);
    check("post_rst_quiet", 64'(saw_en), 64'd0);

    // Bubble behaviour after a single beat of 20.
    drive(1'b1, 1'b1, rep(20)); edge1();
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) edge1();
    check("bub_tile_beats", 64'(tile_beats), 64'd1);
    check("bub_en_i", 64'(en_i), 64'd0);
    for (int h = 0; h < H; h++)
      check($sformatf("bub_ifm%0d", h), 64'($unsigned(ifm[h])), 64'(BUBBLE_20));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifm_skew_feeder.md
Name: ifm_skew_feeder

Overview:
- Upstream stage of the 2-D systolic array. It takes one HEIGHT-wide input-feature-map vector per accepted beat through a valid/ready handshake.
- It drives the array's row ports (ifm, en_i, clr_i) with diagonal skew: row h is delayed h cycles relative to row 0.
- A small FSM frames tiles. After the last beat of a tile it blocks input, pushes a clr token down the skew, and signals tile completion.

Parameters:
- HEIGHT, 32, number of array rows / vector lanes.
- IWIDTH, 16, signed element width.
- CNT_W, 16, width of the per-tile beat counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream vector valid.
- s_ready  output  1  feeder can accept a vector.
- s_last  input  1  accompanies the final vector of a tile.
- s_data  input  HEIGHT x IWIDTH signed (unpacked [HEIGHT-1:0])  input vector; lane h feeds row h.
- ifm  output  HEIGHT x IWIDTH signed (unpacked [HEIGHT-1:0])  skewed row data to the array.
- en_i  output  HEIGHT  per-row data-valid, skewed.
- clr_i  output  HEIGHT  per-row clear pulse, skewed.
- busy  output  1  high in STREAM or FLUSH.
- tile_done  output  1  one-cycle pulse when clr reaches row HEIGHT-1.
- tile_beats  output  CNT_W  beat count of the most recently completed tile.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: ifm all 0, en_i 0, clr_i 0, busy 0, tile_done 0, tile_beats 0, FSM in IDLE, beat counter 0, every skew stage cleared.
- Skew pipeline:
  - Lane h is a chain of h+1 registers holding {en, clr, data}. All lanes shift every cycle; the array applies no back-pressure.
  - A token injected at edge T appears on row h outputs from edge T+h+1 onward.
- Injection, each cycle: en token = s_valid && s_ready; clr token = the FLUSH-entry flag; data = s_data.
- Handshake:
  - s_ready = (state != FLUSH).
  - Accept = s_valid && s_ready.
  - s_valid low during IDLE or STREAM injects a bubble (en=0). The skew alignment is preserved.
- FSM states and transitions:
  - IDLE: accept without s_last goes to STREAM with counter=1. Accept with s_last (single-beat tile) goes directly to FLUSH with counter=1.
  - STREAM: each accept increments the counter, saturating at all-ones. Accept with s_last goes to FLUSH.
  - FLUSH: lasts exactly HEIGHT+1 cycles.
    - Cycle 0 injects the clr token with en=0. Row h then sees clr_i[h]=1 exactly one cycle after its last en_i[h] beat.
    - On the last FLUSH cycle, tile_done pulses, coincident with clr_i[HEIGHT-1].
    - tile_beats loads the counter, the counter clears, and the FSM returns to IDLE.
- Boundary conditions:
  - s_last with s_valid low is ignored.
  - A new tile's first beat can be accepted the cycle after tile_done.
  - Counter saturation does not affect framing.
  - Reset asserted mid-tile clears everything immediately: the in-flight skew tokens are discarded and no tile_done is generated.
- Busy: busy=1 in STREAM or FLUSH.

Optional Feature:
- Macro: IFM_SKEW_ZERO_GATE_EN.
- Defined: data stages load s_data only when the en token is 1 and load 0 otherwise, so ifm[h] is 0 whenever en_i[h]=0. This avoids toggling in idle rows.
- Undefined: data stages load only when the en token is 1 and otherwise hold their previous value. ifm[h] during bubbles is the last valid element of that row.
- en_i and clr_i timing are identical in both builds.

Decomposition:
- Shared package (array pkg): typedef elem_t = logic signed [IWIDTH-1:0]; enum fsm_t {IDLE, STREAM, FLUSH}; localparam FLUSH_LEN = HEIGHT+1.
- One natural sub-module, skew_lane: a parameterised DEPTH-register delay line carrying {en, clr, data}. It is instantiated HEIGHT times with DEPTH=h+1 via generate.

Test Plan (HEIGHT=4, IWIDTH=16):
- Reset, then one accepted beat s_data={4,3,2,1} with s_last=1 -> en_i[0] at edge 1 with ifm[0]=1; en_i[3] at edge 4 with ifm[3]=4; clr_i[h] at edge h+2; tile_done at edge 5; tile_beats=1; s_ready low for 5 cycles.
- Three back-to-back beats (10,20,30 on every lane), last on the third -> each row shows 10,20,30 on consecutive cycles offset by h; tile_beats=3; the next accept is allowed on the cycle after tile_done.
- Beat, one-cycle s_valid gap, beat+last -> row h shows en pattern 1,0,1 and clr one cycle after the second en; tile_beats=2.
- s_valid held high through FLUSH -> no accept while s_ready=0; the pending vector is accepted the cycle after tile_done and is not duplicated or dropped.
- rst_n asserted while beats 2 and 3 are in the skew -> all outputs 0 immediately and asynchronously; no tile_done; the FSM is in IDLE after release.
- Bubble check in both builds -> with IFM_SKEW_ZERO_GATE_EN, ifm[h]=0 during bubbles; without it, ifm[h] holds 20 after a beat of 20.
